// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the execute stage and the multi-cycle
// multiply/divide unit.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic               start_i;
    logic [1:0]         op_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;
    logic               stallreq_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, busy_o, stallreq_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, busy_o, stallreq_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle signed/unsigned multiply (shift-add) and divide (restoring),
// one bit per cycle, returning {HI, LO}.
module ex_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               is_div_reg;
    logic               neg_lo_reg;
    logic               neg_hi_reg;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide: low half shifts dividend bits out and quotient bits in.
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH:0]     rem_reg;
    logic [WIDTH-1:0]   opb_reg;
    logic [2*WIDTH-1:0] result_reg;
    logic               ready_reg;
    logic               busy_reg;

    logic [WIDTH-1:0]   opd [2];
    logic [WIDTH-1:0]   abs_opd [2];
    logic               sgn [2];

    assign opd[0] = bus.opdata1_i;
    assign opd[1] = bus.opdata2_i;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_abs
            assign sgn[gi]     = ~bus.op_i[0] & opd[gi][WIDTH-1];
            assign abs_opd[gi] = sgn[gi] ? -opd[gi] : opd[gi];
        end
    endgenerate

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH+1:0]   rem_shift;
    logic               div_ge;
    logic [WIDTH:0]     rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [2*WIDTH-1:0] fin_result;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
        mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};

        rem_shift = {rem_reg, acc_reg[WIDTH-1]};
        div_ge    = rem_shift >= {2'b00, opb_reg};
        rem_next  = div_ge ? (rem_shift[WIDTH:0] - {1'b0, opb_reg}) : rem_shift[WIDTH:0];
        quo_next  = {acc_reg[WIDTH-2:0], div_ge};

        // Sign fix-up of the final iteration's values, so DONE holds a finished result
        if (is_div_reg) begin
            fin_result = {(neg_hi_reg ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0]),
                          (neg_lo_reg ? -quo_next : quo_next)};
        end else begin
            fin_result = neg_lo_reg ? -mul_next : mul_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
            acc_reg    <= '0;
            rem_reg    <= '0;
            opb_reg    <= '0;
            result_reg <= '0;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start_i && !bus.annul_i) begin
                        is_div_reg <= bus.op_i[1];
                        neg_lo_reg <= sgn[0] ^ sgn[1];
                        neg_hi_reg <= sgn[0];
                        cnt_reg    <= '0;
                        rem_reg    <= '0;
                        if (bus.op_i[1] && (bus.opdata2_i == '0)) begin
                            result_reg <= {bus.opdata1_i, {WIDTH{1'b1}}};
                            ready_reg  <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            acc_reg   <= {{WIDTH{1'b0}}, (bus.op_i[1] ? abs_opd[0] : abs_opd[1])};
                            opb_reg   <= bus.op_i[1] ? abs_opd[1] : abs_opd[0];
                            busy_reg  <= 1'b1;
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.annul_i) begin
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        acc_reg <= is_div_reg ? {acc_reg[2*WIDTH-1:WIDTH], quo_next} : mul_next;
                        rem_reg <= rem_next;
                        if (cnt_reg == CNT_W'(WIDTH-1)) begin
                            result_reg <= fin_result;
                            ready_reg  <= 1'b1;
                            busy_reg   <= 1'b0;
                            cnt_reg    <= '0;
                            state_reg  <= DONE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.result_o   = result_reg;
    assign bus.ready_o    = ready_reg;
    assign bus.busy_o     = busy_reg;
    assign bus.stallreq_o = ((state_reg == IDLE) && bus.start_i && !bus.annul_i) || (state_reg == RUN);
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit attached to the execute stage; successor to the single-cycle EX arithmetic path.
- Computes signed/unsigned multiply and divide over WIDTH-bit operands and returns a {HI, LO} pair for the HI/LO register file.
- Holds the pipeline through `stallreq_o` while an operation is in flight.
- Supports annulment when the issuing instruction is squashed.

Parameters:
- WIDTH, 32, operand width in bits; must be ≥ 4 and even.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  request a new operation; sampled only in IDLE.
- op_i  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- opdata1_i  input  WIDTH  multiplicand / dividend.
- opdata2_i  input  WIDTH  multiplier / divisor.
- annul_i  input  1  abort the in-flight operation (e.g. branch or flush).
- result_o  output  2*WIDTH  {HI, LO}.
  - Multiply: HI = upper product, LO = lower product.
  - Divide: HI = remainder, LO = quotient.
- ready_o  output  1  result_o valid this cycle; single-cycle pulse.
- busy_o  output  1  unit is in the RUN state.
- stallreq_o  output  1  pipeline stall request; combinational.

Behaviour:
- Reset: state = IDLE; counter = 0; result_o = 0; ready_o = 0; busy_o = 0. rst overrides every other input, including mid-operation; no result is produced for an aborted operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start_i && !annul_i: latch op_i, |opdata1_i|, |opdata2_i| (absolute values only for signed ops), and the result signs.
    - Result sign, MULT: sign1 XOR sign2.
    - Quotient sign, DIV: sign1 XOR sign2.
    - Remainder sign, DIV: sign1.
  - Divide with opdata2_i == 0: go to DONE with HI = opdata1_i (unmodified) and LO = all-ones.
  - Otherwise: go to RUN with counter = 0.
- RUN, multiply: shift-add, one multiplier bit per cycle, LSB first, into a 2*WIDTH accumulator.
- RUN, divide: restoring, one quotient bit per cycle, MSB first.
  - Remainder register is WIDTH+1 bits to absorb the carry.
- RUN exit: after exactly WIDTH iterations (counter == WIDTH-1 on the last), go to DONE.
- Sign fix-up: applied when entering DONE (two's-complement negate of the relevant halves); the registered result is then final.
- DONE: ready_o = 1 and result_o holds the result for this one cycle; next state is IDLE.
- result_o after DONE: keeps the last value until the next DONE (verification relies on this).
- Latency: start accepted at edge N → ready_o high in cycle N+WIDTH+1. Divide-by-zero: ready_o high in cycle N+1.
- stallreq_o = (state==IDLE && start_i && !annul_i) || state==RUN. It is low in DONE, so the stalled instruction advances in the same cycle ready_o is high.
- start_i in RUN or DONE: ignored; no queuing.
- annul_i in RUN or DONE: next state IDLE; ready_o stays 0; result_o unchanged. annul_i has priority over the RUN→DONE transition.
- annul_i && start_i in IDLE: no operation started.
- Signed overflow, DIV of most-negative by -1: LO = most-negative value, HI = 0 (natural wrap); no exception raised.
- Operand registers: captured at start; later changes on opdata*_i do not affect the operation.
- busy_o = (state==RUN).

Test Plan:
- WIDTH=32, MULT 0xFFFFFFFD × 0x00000005, start at cycle 0 → ready_o=1 in cycle 33 only; result_o = 0xFFFFFFFF_FFFFFFF1; stallreq_o high cycles 0–32, low in 33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → result_o = 0xFFFFFFFE_00000001.
- DIV 0xFFFFFFF9 (−7) / 2 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFD. DIVU 7/2 → HI = 1, LO = 3.
- DIVU 100 / 0 → ready_o in cycle 1; HI = 0x00000064, LO = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → HI = 0, LO = 0x80000000.
- Abort and restart:
  - Start MULT, assert annul_i in cycle 10 → busy_o = 0 from cycle 11; no ready_o pulse.
  - Separately, start MULT and assert rst in cycle 20 → all outputs 0 next cycle.
  - After either abort, a fresh DIVU 9/3 → HI = 0, LO = 3 after 33 cycles.
